// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_stage
//  Description : Instruction fetch stage of a 5-stage MIPS pipeline. Holds a
//                32-word program memory loaded while not running, a 5-bit
//                word-indexed PC and an IDLE/RUN/HALT controller. Drives the
//                fetched word, PC+1 and the load enable toward IF/ID.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        prog_we,
    input  logic [4:0]  prog_addr,
    input  logic [31:0] prog_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [4:0]  branch_target,
    input  logic        jump,
    input  logic [4:0]  jump_target,
    output logic [31:0] instruccion,
    output logic [4:0]  PC_next,
    output logic        if_id_en,
    output logic        running,
    output logic        halted,
    output logic [15:0] fetch_count
);

    localparam logic [31:0] HALT_WORD   = 32'hFFFF_FFFF;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;
    localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [4:0]  r_pc;
    logic [4:0]  w_pc_next;
    logic [15:0] r_fetch_count;
    logic [15:0] w_fetch_count_next;
    logic [31:0] r_mem [32];

    logic        w_run;
    logic        w_redirect;
    logic        w_issue;
    logic        w_halt_fetch;
    logic [31:0] w_word;
    logic [4:0]  w_pc_inc;

    assign w_run        = (r_state == S_RUN);
    assign w_word       = r_mem[r_pc];
    assign w_pc_inc     = r_pc + 5'd1;
    assign w_redirect   = jump | branch_taken;
    // A fetch is issued only when nothing redirects or holds the pipeline.
    assign w_issue      = w_run & ~w_redirect & ~stall;
    assign w_halt_fetch = w_issue & (w_word == HALT_WORD);

    // Controller, PC and issued-fetch counter next values.
    always_comb begin
        w_state_next       = r_state;
        w_pc_next          = r_pc;
        w_fetch_count_next = r_fetch_count;
        case (r_state)
            S_RUN: begin
                if (jump) begin
                    w_pc_next = jump_target;
                end else if (branch_taken) begin
                    w_pc_next = branch_target;
                end else if (!stall) begin
                    if (w_halt_fetch) begin
                        // PC parks on the halt word.
                        w_state_next = S_HALT;
                    end else begin
                        w_pc_next = w_pc_inc;
                        if (r_fetch_count != C_COUNT_MAX) begin
                            w_fetch_count_next = r_fetch_count + 16'd1;
                        end
                    end
                end
            end
            default: begin
                if (start) begin
                    w_state_next       = S_RUN;
                    w_pc_next          = 5'd0;
                    w_fetch_count_next = 16'd0;
                end
            end
        endcase
    end

    // State, PC and counter registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_pc          <= 5'd0;
            r_fetch_count <= 16'd0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_fetch_count <= w_fetch_count_next;
        end
    end

    // Program memory write port; blocked while running, never cleared.
    always_ff @(posedge clk) begin
        if (prog_we && !w_run) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    // IF/ID-facing outputs; redirect and halt turn the slot into a bubble.
    always_comb begin
        instruccion = NOP_WORD;
        PC_next     = 5'd0;
        if_id_en    = 1'b0;
        if (w_run) begin
            PC_next = w_pc_inc;
            if (w_redirect) begin
                if_id_en = 1'b1;
            end else if (stall) begin
                instruccion = w_word;
            end else if (w_word == HALT_WORD) begin
                if_id_en = 1'b1;
            end else begin
                instruccion = w_word;
                if_id_en    = 1'b1;
            end
        end
    end

    assign running     = w_run;
    assign halted      = (r_state == S_HALT);
    assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_stage
//  Description : Self-checking bench for fetch_stage. Directed program run,
//                stall, redirect, wrap, write protection and async reset,
//                followed by randomized traffic against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        prog_we;
    logic [4:0]  prog_addr;
    logic [31:0] prog_data;
    logic        stall;
    logic        branch_taken;
    logic [4:0]  branch_target;
    logic        jump;
    logic [4:0]  jump_target;
    logic [31:0] instruccion;
    logic [4:0]  PC_next;
    logic        if_id_en;
    logic        running;
    logic        halted;
    logic [15:0] fetch_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: 0 = idle, 1 = run, 2 = halt.
    logic [31:0] m_mem [32];
    int          m_state = 0;
    int          m_pc    = 0;
    int          m_cnt   = 0;

    logic [31:0] prog [4];

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .prog_we       (prog_we),
        .prog_addr     (prog_addr),
        .prog_data     (prog_data),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .instruccion   (instruccion),
        .PC_next       (PC_next),
        .if_id_en      (if_id_en),
        .running       (running),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle from the model state and inputs.
    task automatic compare_model();
        logic [31:0] w;
        logic [31:0] e_instr;
        logic [4:0]  e_pcn;
        logic        e_en;
        e_instr = 32'h0;
        e_pcn   = 5'd0;
        e_en    = 1'b0;
        if (m_state == 1) begin
            w     = m_mem[m_pc];
            e_pcn = 5'((m_pc + 1) % 32);
            if (jump || branch_taken) begin
                e_en = 1'b1;
            end else if (stall) begin
                e_instr = w;
            end else if (w == HALT_WORD) begin
                e_en = 1'b1;
            end else begin
                e_instr = w;
                e_en    = 1'b1;
            end
        end
        check("instruccion", instruccion, e_instr);
        check("PC_next", 32'(PC_next), 32'(e_pcn));
        check("if_id_en", 32'(if_id_en), 32'(e_en));
        check("running", 32'(running), 32'(m_state == 1));
        check("halted", 32'(halted), 32'(m_state == 2));
        check("fetch_count", 32'(fetch_count), 32'(m_cnt));
    endtask

    // Advance the model by one rising edge using the inputs just sampled.
    task automatic model_update();
        if (m_state == 1) begin
            if (jump) begin
                m_pc = int'(jump_target);
            end else if (branch_taken) begin
                m_pc = int'(branch_target);
            end else if (!stall) begin
                if (m_mem[m_pc] == HALT_WORD) begin
                    m_state = 2;
                end else begin
                    m_pc = (m_pc + 1) % 32;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
        end else begin
            if (prog_we) m_mem[prog_addr] = prog_data;
            if (start) begin
                m_state = 1;
                m_pc    = 0;
                m_cnt   = 0;
            end
        end
    endtask

    task automatic cyc(input logic s, input logic we, input logic [4:0] pa, input logic [31:0] pd,
                       input logic st, input logic br, input logic [4:0] bt,
                       input logic j, input logic [4:0] jt);
        @(negedge clk);
        start         = s;
        prog_we       = we;
        prog_addr     = pa;
        prog_data     = pd;
        stall         = st;
        branch_taken  = br;
        branch_target = bt;
        jump          = j;
        jump_target   = jt;
        #1;
        compare_model();
    endtask

    task automatic idle_cyc();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
    endtask

    // Pulse reset between edges and verify outputs clear immediately.
    task automatic mid_reset();
        #1 reset = 1'b1;
        #1;
        check("rst_instr", instruccion, 32'h0);
        check("rst_pcnext", 32'(PC_next), 32'h0);
        check("rst_en", 32'(if_id_en), 32'h0);
        check("rst_running", 32'(running), 32'h0);
        check("rst_halted", 32'(halted), 32'h0);
        check("rst_count", 32'(fetch_count), 32'h0);
        reset   = 1'b0;
        m_state = 0;
        m_pc    = 0;
        m_cnt   = 0;
    endtask

    initial begin
        logic [31:0] word;
        prog[0] = 32'h2001_0005;
        prog[1] = 32'h2002_0003;
        prog[2] = 32'h0022_1820;
        prog[3] = HALT_WORD;

        reset = 1'b1; start = 1'b0; prog_we = 1'b0; prog_addr = 5'd0; prog_data = 32'h0;
        stall = 1'b0; branch_taken = 1'b0; branch_target = 5'd0; jump = 1'b0; jump_target = 5'd0;
        #2;
        check("reset_instr", instruccion, 32'h0);
        check("reset_running", 32'(running), 32'h0);
        check("reset_halted", 32'(halted), 32'h0);
        check("reset_en", 32'(if_id_en), 32'h0);
        #10 reset = 1'b0;

        // Load program; remaining words are random non-halt values.
        for (int i = 0; i < 32; i++) begin
            if (i < 4) begin
                word = prog[i];
            end else begin
                word = $urandom;
                if (word == HALT_WORD) word = 32'h1;
            end
            cyc(1'b0, 1'b1, 5'(i), word, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
            tick();
        end

        // Program run to halt.
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        for (int k = 0; k < 3; k++) begin
            idle_cyc();
            check("prog_word", instruccion, prog[k]);
            check("prog_pcnext", 32'(PC_next), 32'(k + 1));
            tick();
        end
        idle_cyc();
        check("halt_bubble", instruccion, 32'h0);
        check("halt_bubble_en", 32'(if_id_en), 32'h1);
        tick();
        idle_cyc();
        check("halted_flag", 32'(halted), 32'h1);
        check("halted_count", 32'(fetch_count), 32'd3);
        tick();

        // Restart, stall twice at pc 1, then combined redirect at pc 2.
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle_cyc();
        tick();
        for (int k = 0; k < 2; k++) begin
            cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0);
            check("stall_en", 32'(if_id_en), 32'h0);
            check("stall_pcnext", 32'(PC_next), 32'd2);
            tick();
        end
        idle_cyc();
        check("resume_word", instruccion, prog[1]);
        tick();
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 5'd7, 1'b1, 5'd12);
        check("redir_bubble", instruccion, 32'h0);
        check("redir_en", 32'(if_id_en), 32'h1);
        tick();
        // Write to address 0 during RUN must be dropped.
        cyc(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        check("target_pcnext", 32'(PC_next), 32'd13);
        tick();

        // Sequential run through 31 -> 0 wrap until the halt word.
        for (int k = 0; k < 40 && m_state == 1; k++) begin
            idle_cyc();
            tick();
        end
        idle_cyc();
        check("wrap_halted", 32'(halted), 32'h1);
        check("wrap_count", 32'(fetch_count), 32'd25);
        tick();

        // Restart shows mem[0] untouched by the RUN-time write.
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle_cyc();
        check("protect_word", instruccion, prog[0]);
        tick();
        idle_cyc();
        mid_reset();
        tick();
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        tick();
        idle_cyc();
        check("post_reset_word", instruccion, prog[0]);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 600; c++) begin
            word = ($urandom_range(0, 5) == 0) ? HALT_WORD : $urandom;
            cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, 5'($urandom_range(0, 31)), word,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)),
                $urandom_range(0, 9) == 0, 5'($urandom_range(0, 31)));
            if ($urandom_range(0, 99) == 0) mid_reset();
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
